spr_fetch: RTL and testbench
============================

Name: spr_fetch

Overview:
- Per-scanline sprite evaluation and fetch engine.
- Scans the 64-entry OAM for sprites that intersect the next scanline and fetches their two pattern bytes from the pattern table.
- Assembles one 32-bit render word per sprite and loads it into one of the eight per-sprite renderers, selected by slot index, with a load strobe.
- Producer side of the sprite render-word interface.

Parameters:
- SPR_TABLE, 1'b0, pattern-table select bit for sprites (pat_addr[12]).
- MAX_SPR, 8, render slots per line; the (MAX_SPR+1)th hit sets overflow.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- line_start  in  1  one-cycle pulse: begin evaluation for `scanline`.
- scanline  in  8  target line; captured on line_start.
- oam_addr  out  8  OAM byte address, registered.
- oam_data  in  8  OAM read data; valid the cycle after oam_addr changes.
- pat_addr  out  13  pattern address {SPR_TABLE, tile[7:0], plane, row[2:0]}, registered.
- pat_data  in  8  pattern read data; 1-cycle latency.
- spr_word  out  32  render word.
- spr_slot  out  3  target renderer slot.
- spr_load  out  1  one-cycle strobe; spr_word and spr_slot are valid only while it is high.
- slot_valid  out  8  bit n set when slot n was loaded this line; drives the renderer draw enables.
- sprite_overflow  out  1  more than MAX_SPR sprites hit this line.
- busy  out  1  high from the cycle after line_start until done.
- done  out  1  one-cycle pulse when the line's fetch is complete.

Behaviour:
- Render word format:
  - [7:0] low plane
  - [15:8] high plane
  - [23:16] X
  - [25:24] palette (attr[1:0])
  - [28:26] zero
  - [29] priority (attr[5])
  - [30] hflip (attr[6])
  - [31] zero
  - Pattern bytes are stored unflipped; the renderer applies hflip.
- OAM entry n occupies bytes 4n..4n+3: Y, tile, attr, X.
- Reset: every output is 0, state is IDLE, the captured scanline is 0, the hit list is empty.
- States: IDLE, EV_ADDR, EV_CHK, F_TILE_A, F_TILE_D, F_ATTR_A, F_ATTR_D, F_X_A, F_X_D, F_LO_A, F_LO_D, F_HI_A, F_HI_D, LOAD, DONE.
- line_start (any state, any cycle):
  - captures scanline;
  - clears slot_valid, sprite_overflow and the hit count;
  - sets n=0 and enters EV_ADDR next cycle;
  - aborts any fetch in progress (no further spr_load for the old line);
  - simultaneous reset wins.
- EV_ADDR: oam_addr={n,2'b00}.
- EV_CHK evaluates row = scanline - oam_data, 8-bit wrap:
  - Hit iff row < 8 (unsigned); the sprite index is appended to the hit list.
  - Y == scanline is a hit (row 0); Y == scanline-7 is a hit (row 7).
  - Y == scanline-8 misses; Y > scanline wraps to a large row and misses.
  - A hit that would be hit number MAX_SPR+1 sets sprite_overflow=1, is not appended, and ends evaluation immediately.
  - Otherwise n increments. After n=63 go to fetch with k=0, or straight to DONE if the hit count is 0.
- Fetch, per hit k, in OAM order:
  - Each *_A state drives an address; each *_D state latches data.
  - Y is re-read in F_TILE_A/D to recompute row.
  - vflip (attr[7]) replaces row with 7-row.
  - LO uses plane 0; HI uses plane 1.
  - LOAD: spr_load=1, spr_slot=k, spr_word assembled, slot_valid[k]<=1. Then k++; if k == hit count go to DONE, else F_TILE_A.
  - The F_TILE pair covers both the Y and tile reads (4 cycles); each other A/D pair is 2 cycles.
- DONE: done=1 for one cycle; busy falls in the same cycle; then IDLE.
- Latency, cycles counted from the line_start edge:
  - Full 64-entry evaluation: 128 cycles.
  - Each hit: 13 cycles (Y 2 + tile 2 + attr 2 + X 2 + lo 2 + hi 2 + LOAD 1).
  - DONE lands at cycle 129 + 13·hits (no overflow).
  - On overflow, evaluation ends at the overflowing EV_CHK.
- Between strobes spr_load=0, and spr_word/spr_slot hold their last value.
- oam_addr and pat_addr hold their last value when idle.

Decomposition:
- spr_pkg holds:
  - render-word bit positions (LO, HI, XPOS, PAL, PRIO, HFLIP);
  - OAM byte offsets (Y=0, TILE=1, ATTR=2, X=3);
  - attr bit positions (VFLIP=7, HFLIP=6, PRIO=5);
  - the state enum.
- One sub-module: spr_word_pack, combinational; takes {lo, hi, x, attr} and produces the 32-bit word. It is shared with the renderer's bench model.

Test Plan:
1. OAM[0]={Y=10, tile=0x21, attr=0x03, X=0x40}, other entries Y=0xFF; pattern data lo=0xA5, hi=0x3C; scanline=12 -> pat_addr 0x212 then 0x21A; one spr_load with slot 0 and word 0x03403CA5; slot_valid=0x01; done at cycle 142.
2. Same setup with attr=0xE0 -> row 5, pat_addr 0x215/0x21D; word bits 30,29 set, palette 0; word 0x60403CA5.
3. Nine sprites hit line 20 (entries 3,5,...,19) -> eight loads to slots 0..7 with OAM indices 3..17 in order; entry 19 is not loaded; sprite_overflow=1; slot_valid=0xFF.
4. All Y=0xFF, scanline=100 -> no spr_load; slot_valid=0; done exactly at cycle 129; busy high for cycles 1..128.
5. Boundary at scanline=50 with Y values 50, 43, 42 and 51 -> only Y=50 and Y=43 load, with rows 0 and 7.
6. line_start during F_LO_D of hit 1 -> no load for old hit 1; slot_valid cleared; new evaluation runs to completion. Separately, reset asserted mid-fetch -> all outputs 0 next cycle and no spr_load.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared definitions for the sprite evaluation/fetch engine: render-word layout,
// OAM byte layout, attribute bits and the fetch FSM states.
package spr_pkg;

    localparam int W_LO_LSB   = 0;
    localparam int W_HI_LSB   = 8;
    localparam int W_XPOS_LSB = 16;
    localparam int W_PAL_LSB  = 24;
    localparam int W_PRIO     = 29;
    localparam int W_HFLIP    = 30;

    localparam logic [1:0] OAM_Y    = 2'd0;
    localparam logic [1:0] OAM_TILE = 2'd1;
    localparam logic [1:0] OAM_ATTR = 2'd2;
    localparam logic [1:0] OAM_X    = 2'd3;

    localparam int ATTR_VFLIP = 7;
    localparam int ATTR_HFLIP = 6;
    localparam int ATTR_PRIO  = 5;

    typedef enum logic [3:0] {
        IDLE, EV_ADDR, EV_CHK,
        F_TILE_A, F_TILE_D, F_ATTR_A, F_ATTR_D, F_X_A, F_X_D,
        F_LO_A, F_LO_D, F_HI_A, F_HI_D, LOAD, DONE
    } spr_state_e;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
    } spr_fields_t;

endpackage

// File: rtl/spr_word_pack.sv
// Packs fetched sprite fields into the 32-bit render word; pattern bytes stay
// unflipped, hflip is carried as a flag for the renderer.
module spr_word_pack
    import spr_pkg::*;
(
    input  spr_fields_t f,
    output logic [31:0] word
);

    logic unused_attr;
    assign unused_attr = ^{f.attr[7], f.attr[4:2]};

    always_comb begin
        word                     = '0;
        word[W_LO_LSB +: 8]      = f.lo;
        word[W_HI_LSB +: 8]      = f.hi;
        word[W_XPOS_LSB +: 8]    = f.x;
        word[W_PAL_LSB +: 2]     = f.attr[1:0];
        word[W_PRIO]             = f.attr[ATTR_PRIO];
        word[W_HFLIP]            = f.attr[ATTR_HFLIP];
    end

endmodule

// File: rtl/spr_fetch.sv
// Per-scanline sprite evaluation (64-entry OAM scan) followed by a pattern
// fetch per hit, loading one render word per renderer slot.
module spr_fetch
    import spr_pkg::*;
#(
    parameter logic SPR_TABLE = 1'b0,
    parameter int   MAX_SPR   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  scanline,
    output logic [7:0]  oam_addr,
    input  logic [7:0]  oam_data,
    output logic [12:0] pat_addr,
    input  logic [7:0]  pat_data,
    output logic [31:0] spr_word,
    output logic [2:0]  spr_slot,
    output logic        spr_load,
    output logic [7:0]  slot_valid,
    output logic        sprite_overflow,
    output logic        busy,
    output logic        done
);

    localparam int SW = $clog2(MAX_SPR);
    localparam int CW = $clog2(MAX_SPR + 1);

    spr_state_e        state, state_d;
    logic [5:0]        n;
    logic [SW-1:0]     k, k_next;
    logic [CW-1:0]     hit_cnt;
    logic [5:0]        hit_idx [MAX_SPR];
    logic [7:0]        line_q;
    logic              ph;
    logic [2:0]        row;
    logic [7:0]        tile, attr, xpos, lo;
    logic [7:0]        row_calc;
    logic              hit;
    logic [5:0]        cur_idx;
    logic [2:0]        row_eff;
    logic [7:0]        oam_addr_d;
    logic [12:0]       pat_addr_d;
    logic [31:0]       word_next;
    spr_fields_t       fields;

    // Same subtraction serves the hit test and the fetch-time row recompute.
    assign row_calc = line_q - oam_data;
    assign hit      = (row_calc[7:3] == 5'd0);
    assign row_eff  = attr[ATTR_VFLIP] ? ~row : row;
    assign k_next   = (state == LOAD) ? k + 1'b1 : k;

    // The final entry's own hit is not in the list yet when fetch starts.
    assign cur_idx = (state == EV_CHK && hit_cnt == '0) ? n : hit_idx[k_next];

    assign fields = '{attr: attr, x: xpos, hi: pat_data, lo: lo};

    spr_word_pack u_pack (
        .f    (fields),
        .word (word_next)
    );

    assign spr_load = (state == LOAD);
    assign done     = (state == DONE);
    assign busy     = (state != IDLE) && (state != DONE);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = IDLE;
            EV_ADDR:  state_d = EV_CHK;
            EV_CHK: begin
                if (hit && hit_cnt == CW'(MAX_SPR))
                    state_d = F_TILE_A;
                else if (&n)
                    state_d = (hit || hit_cnt != '0) ? F_TILE_A : DONE;
                else
                    state_d = EV_ADDR;
            end
            F_TILE_A: state_d = F_TILE_D;
            F_TILE_D: state_d = ph ? F_ATTR_A : F_TILE_A;
            F_ATTR_A: state_d = F_ATTR_D;
            F_ATTR_D: state_d = F_X_A;
            F_X_A:    state_d = F_X_D;
            F_X_D:    state_d = F_LO_A;
            F_LO_A:   state_d = F_LO_D;
            F_LO_D:   state_d = F_HI_A;
            F_HI_A:   state_d = F_HI_D;
            F_HI_D:   state_d = LOAD;
            LOAD:     state_d = (CW'(k) + CW'(1) == hit_cnt) ? DONE : F_TILE_A;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (line_start)
            state_d = EV_ADDR;
    end

    // Addresses are registered on entry to each address state so the memories
    // return data in the following cycle.
    always_comb begin
        oam_addr_d = oam_addr;
        pat_addr_d = pat_addr;
        case (state_d)
            EV_ADDR:  oam_addr_d = line_start ? 8'h00 : {n + 6'd1, 2'b00};
            F_TILE_A: oam_addr_d = {cur_idx, (state == F_TILE_D) ? OAM_TILE : OAM_Y};
            F_ATTR_A: oam_addr_d = {cur_idx, OAM_ATTR};
            F_X_A:    oam_addr_d = {cur_idx, OAM_X};
            F_LO_A:   pat_addr_d = {SPR_TABLE, tile, 1'b0, row_eff};
            F_HI_A:   pat_addr_d = {SPR_TABLE, tile, 1'b1, row_eff};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            n               <= '0;
            k               <= '0;
            hit_cnt         <= '0;
            for (int i = 0; i < MAX_SPR; i++) hit_idx[i] <= '0;
            line_q          <= '0;
            ph              <= 1'b0;
            row             <= '0;
            tile            <= '0;
            attr            <= '0;
            xpos            <= '0;
            lo              <= '0;
            oam_addr        <= '0;
            pat_addr        <= '0;
            spr_word        <= '0;
            spr_slot        <= '0;
            slot_valid      <= '0;
            sprite_overflow <= 1'b0;
        end else begin
            state    <= state_d;
            oam_addr <= oam_addr_d;
            pat_addr <= pat_addr_d;
            if (line_start) begin
                line_q          <= scanline;
                n               <= '0;
                k               <= '0;
                ph              <= 1'b0;
                hit_cnt         <= '0;
                slot_valid      <= '0;
                sprite_overflow <= 1'b0;
            end else begin
                case (state)
                    EV_CHK: begin
                        n <= n + 6'd1;
                        if (hit) begin
                            if (hit_cnt == CW'(MAX_SPR)) begin
                                sprite_overflow <= 1'b1;
                            end else begin
                                hit_idx[hit_cnt[SW-1:0]] <= n;
                                hit_cnt                  <= hit_cnt + 1'b1;
                            end
                        end
                    end
                    F_TILE_D: begin
                        ph <= ~ph;
                        if (ph) tile <= oam_data;
                        else    row  <= row_calc[2:0];
                    end
                    F_ATTR_D: attr <= oam_data;
                    F_X_D:    xpos <= oam_data;
                    F_LO_D:   lo   <= pat_data;
                    F_HI_D: begin
                        spr_word <= word_next;
                        spr_slot <= 3'(k);
                    end
                    LOAD: begin
                        slot_valid[k] <= 1'b1;
                        k             <= k + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spr_fetch.sv
// Directed and randomized line evaluations against a behavioural OAM/pattern model.
module tb_spr_fetch;

    logic        clk = 1'b0;
    logic        reset, line_start;
    logic [7:0]  scanline, oam_addr, oam_data, pat_data, slot_valid;
    logic [12:0] pat_addr;
    logic [31:0] spr_word;
    logic [2:0]  spr_slot;
    logic        spr_load, sprite_overflow, busy, done;

    spr_fetch #(.SPR_TABLE(1'b0), .MAX_SPR(8)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .scanline(scanline),
        .oam_addr(oam_addr), .oam_data(oam_data), .pat_addr(pat_addr), .pat_data(pat_data),
        .spr_word(spr_word), .spr_slot(spr_slot), .spr_load(spr_load),
        .slot_valid(slot_valid), .sprite_overflow(sprite_overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] oam     [256];
    logic [7:0] pat_mem [8192];

    always @(posedge clk) begin
        oam_data <= oam[oam_addr];
        pat_data <= pat_mem[pat_addr];
    end

    int vectors = 0, miscompares = 0;

    logic [31:0] exp_word[$];
    logic [12:0] exp_pat[$];
    bit          exp_ovf;
    int          exp_done;

    logic [31:0] ld_word[$];
    int          ld_slot[$];
    logic [12:0] pa_seq[$];
    int          done_cyc, busy_bad;
    bit          got_done, busy_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) begin
            oam[4*i] = 8'hFF; oam[4*i+1] = 8'h00; oam[4*i+2] = 8'h00; oam[4*i+3] = 8'h00;
        end
    endtask

    task automatic set_spr(input int e, input logic [7:0] y, t, a, x);
        oam[4*e] = y; oam[4*e+1] = t; oam[4*e+2] = a; oam[4*e+3] = x;
    endtask

    // Reference: first eight intersecting entries in OAM order, ninth flags overflow.
    task automatic model(input logic [7:0] s);
        int hits[$];
        int ovf_e;
        logic [7:0] r, y, t, a, x;
        logic [12:0] la;
        exp_word.delete(); exp_pat.delete();
        exp_ovf = 0; ovf_e = 0;
        for (int e = 0; e < 64; e++) begin
            r = s - oam[4*e];
            if (r < 8) begin
                if (hits.size() == 8) begin exp_ovf = 1; ovf_e = e; break; end
                hits.push_back(e);
            end
        end
        exp_done = exp_ovf ? (2*ovf_e + 2) + 1 + 13*8 : 129 + 13*hits.size();
        foreach (hits[i]) begin
            y = oam[4*hits[i]]; t = oam[4*hits[i]+1]; a = oam[4*hits[i]+2]; x = oam[4*hits[i]+3];
            r = s - y;
            if (a[7]) r = 7 - r;
            la = {1'b0, t, 1'b0, r[2:0]};
            exp_pat.push_back(la);
            exp_pat.push_back(la | 13'h8);
            exp_word.push_back({1'b0, a[6], a[5], 3'b000, a[1:0], x, pat_mem[la | 13'h8], pat_mem[la]});
        end
    endtask

    // Pulses line_start in the current cycle; abort_at>0 returns at that cycle's negedge.
    task automatic run_line(input logic [7:0] s, input int abort_at);
        int cyc;
        logic [12:0] prev_pa;
        scanline = s; line_start = 1'b1;
        ld_word.delete(); ld_slot.delete(); pa_seq.delete();
        got_done = 0; busy_bad = 0; busy_at_done = 1; done_cyc = -1;
        @(negedge clk); line_start = 1'b0; cyc = 1;
        chk("slot_valid_cleared", slot_valid, 8'h00);
        prev_pa = pat_addr;
        while (cyc < 2000) begin
            if (abort_at != 0 && cyc == abort_at) break;
            if (pat_addr !== prev_pa) begin pa_seq.push_back(pat_addr); prev_pa = pat_addr; end
            if (spr_load === 1'b1) begin ld_slot.push_back(int'(spr_slot)); ld_word.push_back(spr_word); end
            if (done === 1'b1) begin got_done = 1; done_cyc = cyc; busy_at_done = busy; break; end
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk); cyc++;
        end
    endtask

    task automatic check_line(input string tag);
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, "_busy_gaps"}, busy_bad, 0);
        chk({tag, "_nloads"}, ld_word.size(), exp_word.size());
        for (int i = 0; i < ld_word.size() && i < exp_word.size(); i++) begin
            chk({tag, "_slot"}, ld_slot[i], i);
            chk({tag, "_word"}, ld_word[i], exp_word[i]);
        end
        chk({tag, "_overflow"}, 32'(sprite_overflow), 32'(exp_ovf));
        chk({tag, "_slot_valid"}, slot_valid, (32'd1 << exp_word.size()) - 1);
    endtask

    initial begin
        int cnt;
        logic [7:0] s;
        int p;
        for (int i = 0; i < 8192; i++) pat_mem[i] = 8'($urandom);
        clear_oam();
        reset = 1'b1; line_start = 1'b0; scanline = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_oam_addr", oam_addr, 0);
        chk("rst_pat_addr", pat_addr, 0);
        chk("rst_spr_word", spr_word, 0);
        chk("rst_ctl", {spr_load, spr_slot, slot_valid, sprite_overflow, busy, done}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single sprite, no flips
        set_spr(0, 8'd10, 8'h21, 8'h03, 8'h40);
        pat_mem[13'h212] = 8'hA5; pat_mem[13'h21A] = 8'h3C;
        model(8'd12); run_line(8'd12, 0); check_line("t1");
        chk("t1_word_const", (ld_word.size() > 0) ? ld_word[0] : 32'hX, 32'h03403CA5);
        chk("t1_done_const", done_cyc, 142);
        chk("t1_npat", pa_seq.size(), 2);
        if (pa_seq.size() == 2) begin
            chk("t1_pat_lo", pa_seq[0], 13'h212);
            chk("t1_pat_hi", pa_seq[1], 13'h21A);
        end

        // vflip + priority + hflip
        set_spr(0, 8'd10, 8'h21, 8'hE0, 8'h40);
        pat_mem[13'h215] = 8'hA5; pat_mem[13'h21D] = 8'h3C;
        model(8'd12); run_line(8'd12, 0); check_line("t2");
        chk("t2_word_const", (ld_word.size() > 0) ? ld_word[0] : 32'hX, 32'h60403CA5);
        chk("t2_npat", pa_seq.size(), 2);
        if (pa_seq.size() == 2) begin
            chk("t2_pat_lo", pa_seq[0], 13'h215);
            chk("t2_pat_hi", pa_seq[1], 13'h21D);
        end

        // Nine hits: overflow, ninth not loaded
        clear_oam();
        for (int j = 0; j < 9; j++) set_spr(3 + 2*j, 8'd20 - 8'(j % 8), 8'(j + 1), 8'(j), 8'(3 + 2*j));
        model(8'd20); run_line(8'd20, 0); check_line("t3");
        chk("t3_ovf_const", 32'(sprite_overflow), 32'd1);
        chk("t3_sv_const", slot_valid, 8'hFF);
        for (int i = 0; i < ld_word.size(); i++) chk("t3_oam_order", ld_word[i][23:16], 3 + 2*i);

        // No hits
        clear_oam();
        model(8'd100); run_line(8'd100, 0); check_line("t4");
        chk("t4_done_const", done_cyc, 129);

        // Row boundaries: Y=50 (row 0), 43 (row 7), 42 and 51 miss
        set_spr(0, 8'd50, 8'h10, 8'h00, 8'h01);
        set_spr(1, 8'd43, 8'h11, 8'h00, 8'h02);
        set_spr(2, 8'd42, 8'h12, 8'h00, 8'h03);
        set_spr(3, 8'd51, 8'h13, 8'h00, 8'h04);
        model(8'd50); run_line(8'd50, 0); check_line("t5");
        chk("t5_npat", pa_seq.size(), 4);
        if (pa_seq.size() == 4) begin
            chk("t5_pat0", pa_seq[0], 13'h100);
            chk("t5_pat2", pa_seq[2], 13'h117);
        end

        // Restart during F_LO_D of hit 1
        clear_oam();
        set_spr(0, 8'd30, 8'h44, 8'h01, 8'h10);
        set_spr(1, 8'd28, 8'h45, 8'h02, 8'h20);
        run_line(8'd30, 151);
        chk("t6_loads_before_abort", ld_word.size(), 1);
        chk("t6_sv_before_abort", slot_valid, 8'h01);
        model(8'd30); run_line(8'd30, 0); check_line("t6_restart");

        // Reset mid-fetch
        run_line(8'd30, 135);
        reset = 1'b1;
        @(negedge clk);
        chk("t6r_oam_addr", oam_addr, 0);
        chk("t6r_pat_addr", pat_addr, 0);
        chk("t6r_spr_word", spr_word, 0);
        chk("t6r_ctl", {spr_load, spr_slot, slot_valid, sprite_overflow, busy, done}, 0);
        @(negedge clk); reset = 1'b0;
        cnt = 0;
        repeat (30) begin @(negedge clk); if (spr_load !== 1'b0 || busy !== 1'b0) cnt++; end
        chk("t6r_quiet", cnt, 0);

        // Randomized lines
        for (int it = 0; it < 10; it++) begin
            s = 8'($urandom_range(0, 255));
            p = $urandom_range(0, 25);
            for (int e = 0; e < 64; e++) begin
                if ($urandom_range(0, 99) < p) oam[4*e] = s - 8'($urandom_range(0, 9));
                else                           oam[4*e] = 8'($urandom);
                oam[4*e+1] = 8'($urandom); oam[4*e+2] = 8'($urandom); oam[4*e+3] = 8'($urandom);
            end
            model(s); run_line(s, 0); check_line("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
